// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD FIFO feeder: FSM state encoding,
// pixel/word geometry and the frame-size helper.
package lcd_pkg;

  localparam int PIX_W         = 24;  // pixel width pushed into the FIFO
  localparam int BYTES_PER_PIX = 4;   // one pixel per 32-bit memory word
  localparam int CNT_W         = 24;  // wide enough for 12-bit x 12-bit frames

  typedef enum logic [2:0] {
    ST_WAIT_SYNC = 3'd0,
    ST_LOAD      = 3'd1,
    ST_IDLE      = 3'd2,
    ST_REQ       = 3'd3,
    ST_DATA      = 3'd4
  } state_e;

  // Pixels in one frame; the product is formed at full counter width.
  function automatic logic [CNT_W-1:0] frame_pixels(input logic [11:0] hh,
                                                    input logic [11:0] vv);
    return CNT_W'(hh) * CNT_W'(vv);
  endfunction

endpackage

// File: rtl/lcd_fifo_feeder_if.sv
// Bus bundle between the feeder and its neighbours: the FIFO push side and
// the burst-read memory port. The feeder uses the master view.
interface lcd_fifo_feeder_if #(
  parameter int ADDR_W = 32
);
  import lcd_pkg::*;

  // FIFO write side
  logic             fifo_in_req;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [PIX_W-1:0] fifo_wdata;

  // Memory burst-read request
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [7:0]        rd_req_len;

  // Memory read data (no backpressure)
  logic        rd_data_valid;
  logic [31:0] rd_data;
  logic        rd_data_last;

  modport master (
    input  fifo_in_req, fifo_full, rd_req_ready, rd_data_valid, rd_data, rd_data_last,
    output fifo_wr_en, fifo_wdata, rd_req_valid, rd_req_addr, rd_req_len
  );

  modport slave (
    output fifo_in_req, fifo_full, rd_req_ready, rd_data_valid, rd_data, rd_data_last,
    input  fifo_wr_en, fifo_wdata, rd_req_valid, rd_req_addr, rd_req_len
  );

endinterface

// File: rtl/lcd_burst_calc.sv
// Burst sizing: from the pixels still owed in this frame, derive the next
// request length (beats-1) and the byte address following that burst.
module lcd_burst_calc
  import lcd_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 64
) (
  input  logic [CNT_W-1:0]  remaining,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        len_m1,
  output logic [ADDR_W-1:0] next_addr
);

  localparam logic [CNT_W-1:0] MAX_BEATS = CNT_W'(BURST_LEN);

  logic [CNT_W-1:0] beats;

  // Clamp to BURST_LEN; an empty remainder yields len 0 and no address step.
  always_comb begin
    beats     = (remaining > MAX_BEATS) ? MAX_BEATS : remaining;
    len_m1    = (beats == '0) ? 8'd0 : 8'(beats - CNT_W'(1));
    next_addr = addr + ADDR_W'(beats) * ADDR_W'(BYTES_PER_PIX);
  end

endmodule

// File: rtl/lcd_fifo_feeder.sv
// Frame-buffer reader feeding the display pixel FIFO. On frame_sync it
// fetches Hh*Vv pixels in bursts of up to BURST_LEN words while the FIFO
// asks for data, pushing rd_data[23:0] combinationally on each beat.
// Build option: define LCD_FEEDER_PINGPONG_EN to add the buf_sel port and
// choose between FRAME_BASE and FRAME_BASE1 at the start of each frame.
module lcd_fifo_feeder
  import lcd_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                BURST_LEN   = 64,
  parameter logic [ADDR_W-1:0] FRAME_BASE  = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(32'h0080_0000)
) (
  input  logic               wr_clk,
  input  logic               rst,
  input  logic [11:0]        Hh,
  input  logic [11:0]        Vv,
  input  logic               frame_sync,
`ifdef LCD_FEEDER_PINGPONG_EN
  input  logic               buf_sel,
`endif
  lcd_fifo_feeder_if.master  bus,
  output logic               frame_done,
  output logic               overflow,
  output logic               late_frame
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pending_q, pending_d;   // sync seen mid-burst, reload after drain
  logic              overflow_q, overflow_d;
  logic              late_q, late_d;

  logic [CNT_W-1:0]  frame_pix;
  logic [CNT_W-1:0]  rem_dec;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        req_len;
  logic [ADDR_W-1:0] next_addr;
  logic              unused_bits;

  assign frame_pix   = frame_pixels(Hh, Vv);
  assign rem_dec     = (remaining_q == '0) ? '0 : remaining_q - CNT_W'(1);
  assign unused_bits = &{1'b0, bus.rd_data[31:PIX_W]};

`ifdef LCD_FEEDER_PINGPONG_EN
  assign base_addr = buf_sel ? FRAME_BASE1 : FRAME_BASE;
`else
  assign base_addr = FRAME_BASE;
`endif

  assign overflow   = overflow_q;
  assign late_frame = late_q;

  lcd_burst_calc #(
    .ADDR_W   (ADDR_W),
    .BURST_LEN(BURST_LEN)
  ) u_burst_calc (
    .remaining(remaining_q),
    .addr     (addr_q),
    .len_m1   (req_len),
    .next_addr(next_addr)
  );

  // State, counters and sticky flags.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT_SYNC;
      remaining_q <= '0;
      addr_q      <= FRAME_BASE;
      pending_q   <= 1'b0;
      overflow_q  <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      late_q      <= late_d;
    end
  end

  // Next-state and bus outputs; the address advances at the request
  // handshake, which is invisible outside because only one burst is in flight.
  always_comb begin
    state_d          = state_q;
    remaining_d      = remaining_q;
    addr_d           = addr_q;
    pending_d        = pending_q;
    overflow_d       = overflow_q;
    late_d           = late_q;
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr  = '0;
    bus.rd_req_len   = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wdata   = '0;
    frame_done       = 1'b0;

    unique case (state_q)
      ST_WAIT_SYNC: begin
        if (frame_sync) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        remaining_d = frame_pix;
        addr_d      = base_addr;
        pending_d   = 1'b0;
        if (frame_sync) begin
          late_d  = 1'b1;                  // reload again with the newest sync
          state_d = ST_LOAD;
        end else if (frame_pix == '0) begin
          state_d = ST_WAIT_SYNC;          // empty frame: nothing to fetch or report
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (frame_sync) begin
          late_d  = 1'b1;
          state_d = ST_LOAD;
        end else if (bus.fifo_in_req) begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = addr_q;
        bus.rd_req_len   = req_len;
        if (bus.rd_req_ready) begin
          addr_d  = next_addr;
          state_d = ST_DATA;
          if (frame_sync) begin            // accepted burst must still be drained
            late_d    = 1'b1;
            pending_d = 1'b1;
          end
        end else if (frame_sync) begin
          late_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_DATA: begin
        if (bus.rd_data_valid) begin
          remaining_d = rem_dec;           // counts dropped beats too, keeping alignment
          if (bus.fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            bus.fifo_wr_en = 1'b1;
            bus.fifo_wdata = bus.rd_data[PIX_W-1:0];
          end
        end
        if (bus.rd_data_valid && bus.rd_data_last) begin
          if (rem_dec == '0) begin
            frame_done = 1'b1;             // a sync on this beat is on time
            state_d    = (pending_q || frame_sync) ? ST_LOAD : ST_WAIT_SYNC;
          end else begin
            if (frame_sync) late_d = 1'b1;
            if (pending_q || frame_sync) state_d = ST_LOAD;
            else if (bus.fifo_in_req)    state_d = ST_REQ;
            else                         state_d = ST_IDLE;
          end
        end else if (frame_sync) begin
          late_d    = 1'b1;
          pending_d = 1'b1;
        end
      end

      default: state_d = ST_WAIT_SYNC;
    endcase
  end

endmodule

// File: tb/tb_lcd_fifo_feeder.sv
// Self-checking bench for lcd_fifo_feeder. A queue model plans each frame's
// burst requests and pixel stream from Hh, Vv and the base address; a memory
// responder answers requests; a compare process checks every cycle.
// Build option: LCD_FEEDER_PINGPONG_EN adds the buf_sel frame-buffer test.
module tb_lcd_fifo_feeder;
  import lcd_pkg::*;

  localparam int          ADDR_W = 32;
  localparam int          BL     = 4;
  localparam logic [31:0] BASE0  = 32'h0000_0000;
  localparam logic [31:0] BASE1  = 32'h0080_0000;

  logic        wr_clk = 1'b0;
  logic        rst;
  logic [11:0] hh, vv;
  logic        frame_sync;
  logic        frame_done, overflow, late_frame;
`ifdef LCD_FEEDER_PINGPONG_EN
  logic        buf_sel;
`endif

  lcd_fifo_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  lcd_fifo_feeder #(
    .ADDR_W(ADDR_W), .BURST_LEN(BL), .FRAME_BASE(BASE0), .FRAME_BASE1(BASE1)
  ) dut (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .Hh        (hh),
    .Vv        (vv),
    .frame_sync(frame_sync),
`ifdef LCD_FEEDER_PINGPONG_EN
    .buf_sel   (buf_sel),
`endif
    .bus       (bus),
    .frame_done(frame_done),
    .overflow  (overflow),
    .late_frame(late_frame)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } req_t;
  typedef struct { logic [23:0] pix;  bit fin; }         beat_t;

  req_t  exp_req[$];
  beat_t exp_beat[$];

  int checks = 0;
  int errors = 0;
  int n_push, n_hs;
  logic [7:0]  last_len;
  logic [31:0] first_hs_addr, last_hs_addr;
  bit          got_first;

  // memory responder controls
  int          mem_left = 0;
  logic [31:0] mem_addr;
  int          wait_cnt = 0;
  int          ready_delay = 2;
  int          full_beat = -1;
  int          beat_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] pix_of(input logic [31:0] a);
    return a[25:2] ^ 24'h5A_0000;
  endfunction

  // Model: split Hh*Vv pixels into bursts of at most BL words from base.
  task automatic plan_frame(input logic [31:0] base, input int h, input int v);
    int rem, n;
    logic [31:0] a;
    rem = h * v;
    a   = base;
    while (rem > 0) begin
      n = (rem > BL) ? BL : rem;
      exp_req.push_back('{addr: a, len: 8'(n - 1)});
      for (int k = 0; k < n; k++)
        exp_beat.push_back('{pix: pix_of(a + 32'(4 * k)), fin: (rem == n && k == n - 1)});
      a   = a + 32'(4 * n);
      rem = rem - n;
    end
  endtask

  task automatic clear_stats();
    n_push = 0; n_hs = 0; got_first = 0; beat_idx = 0; full_beat = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wr_clk);
    #2;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge wr_clk);
      if (frame_done) seen = 1;
    end
    check({name, "_frame_done_seen"}, seen, 1);
    tick(1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_req_left"},  exp_req.size(),  0);
    check({name, "_beat_left"}, exp_beat.size(), 0);
  endtask

  task automatic count_req_cycles(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge wr_clk);
      if (bus.rd_req_valid) cnt++;
    end
    tick(1);
  endtask

  // Memory: accept a request after ready_delay cycles, then stream its beats.
  initial begin : mem_proc
    bus.rd_req_ready = 0; bus.rd_data_valid = 0; bus.rd_data_last = 0;
    bus.rd_data = '0; bus.fifo_full = 0;
    forever begin
      @(posedge wr_clk); #1;
      bus.rd_req_ready = 0; bus.rd_data_valid = 0; bus.rd_data_last = 0;
      bus.rd_data = '0; bus.fifo_full = 0;
      if (rst) begin
        mem_left = 0; wait_cnt = 0;
      end else if (mem_left > 0) begin
        bus.rd_data_valid = 1;
        bus.rd_data       = {8'hEE, pix_of(mem_addr)};
        bus.rd_data_last  = (mem_left == 1);
        bus.fifo_full     = (beat_idx == full_beat);
        beat_idx++; mem_addr += 4; mem_left--;
      end else if (bus.rd_req_valid) begin
        if (wait_cnt >= ready_delay) begin
          bus.rd_req_ready = 1;
          mem_addr = bus.rd_req_addr;
          mem_left = int'(bus.rd_req_len) + 1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Compare DUT outputs with the model on every cycle outside reset.
  initial begin : cmp_proc
    beat_t b;
    forever begin
      @(negedge wr_clk);
      if (!rst) begin
        if (bus.rd_req_valid) begin
          if (exp_req.size() == 0) begin
            check("req_unexpected", bus.rd_req_valid, 1'b0);
          end else begin
            check("req_addr", bus.rd_req_addr, exp_req[0].addr);
            check("req_len",  bus.rd_req_len,  exp_req[0].len);
            if (bus.rd_req_ready) begin
              n_hs++;
              last_len     = bus.rd_req_len;
              last_hs_addr = bus.rd_req_addr;
              if (!got_first) begin first_hs_addr = bus.rd_req_addr; got_first = 1; end
              void'(exp_req.pop_front());
            end
          end
        end
        if (bus.rd_data_valid && exp_beat.size() != 0) begin
          b = exp_beat.pop_front();
          check("push_en", bus.fifo_wr_en, !bus.fifo_full);
          if (!bus.fifo_full) begin
            check("push_data", bus.fifo_wdata, b.pix);
            n_push++;
          end
          check("frame_done", frame_done, b.fin);
        end else begin
          check("push_idle", bus.fifo_wr_en, 1'b0);
          check("done_idle", frame_done, 1'b0);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   cnt;
    bit   found;
    int   keep;
    rst = 1; hh = 0; vv = 0; frame_sync = 0; bus.fifo_in_req = 0;
`ifdef LCD_FEEDER_PINGPONG_EN
    buf_sel = 0;
`endif
    clear_stats();
    @(negedge wr_clk);
    check("rst_req_valid", bus.rd_req_valid, 0);
    check("rst_req_addr",  bus.rd_req_addr,  0);
    check("rst_req_len",   bus.rd_req_len,   0);
    check("rst_wr_en",     bus.fifo_wr_en,   0);
    check("rst_wdata",     bus.fifo_wdata,   0);
    check("rst_done",      frame_done,       0);
    check("rst_overflow",  overflow,         0);
    check("rst_late",      late_frame,       0);
    tick(1);
    rst = 0;
    tick(2);

    // 1: 8x2 frame, four full bursts
    hh = 8; vv = 2; bus.fifo_in_req = 1;
    clear_stats(); plan_frame(BASE0, 8, 2);
    pulse_sync();
    wait_done("t1", 400);
    check("t1_pushes", n_push, 16);
    check("t1_bursts", n_hs, 4);
    check("t1_first_addr", first_hs_addr, 32'h00);
    check("t1_last_addr", last_hs_addr, 32'h30);
    check("t1_last_len", last_len, 3);
    check_drained("t1");

    // 2: 10x1 frame, short final burst
    hh = 10; vv = 1;
    clear_stats(); plan_frame(BASE0, 10, 1);
    pulse_sync();
    wait_done("t2", 400);
    check("t2_pushes", n_push, 10);
    check("t2_bursts", n_hs, 3);
    check("t2_last_addr", last_hs_addr, 32'h20);
    check("t2_last_len", last_len, 1);
    check_drained("t2");

    // 3: fifo_in_req drops during the first burst
    hh = 8; vv = 1;
    clear_stats(); plan_frame(BASE0, 8, 1);
    pulse_sync();
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge wr_clk);
      if (bus.rd_data_valid) found = 1;
    end
    check("t3_beat_seen", found, 1);
    tick(1);
    bus.fifo_in_req = 0;
    count_req_cycles(12, cnt);
    check("t3_no_req_while_low", cnt, 0);
    check("t3_first_burst_pushed", n_push, 4);
    bus.fifo_in_req = 1;
    wait_done("t3", 400);
    check("t3_bursts", n_hs, 2);
    check("t3_resume_addr", last_hs_addr, 32'h10);
    check_drained("t3");

    // 4: FIFO full on one beat of four
    check("t4_overflow_before", overflow, 0);
    hh = 4; vv = 1;
    clear_stats(); full_beat = 1; plan_frame(BASE0, 4, 1);
    pulse_sync();
    wait_done("t4", 400);
    check("t4_pushes", n_push, 3);
    check("t4_overflow", overflow, 1);
    check_drained("t4");

    // 5: frame_sync in the middle of the second burst
    check("t5_late_before", late_frame, 0);
    hh = 8; vv = 2;
    clear_stats(); plan_frame(BASE0, 8, 2);
    pulse_sync();
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge wr_clk);
      if (bus.rd_data_valid && beat_idx == 6) found = 1;
    end
    check("t5_mid_beat_seen", found, 1);
    tick(1);
    keep = mem_left + (bus.rd_data_valid ? 1 : 0);
    while (exp_beat.size() > keep) void'(exp_beat.pop_back());
    exp_req.delete();
    n_push = 0; n_hs = 0; got_first = 0;
    plan_frame(BASE0, 8, 2);
    pulse_sync();
    check("t5_late", late_frame, 1);
    wait_done("t5", 400);
    check("t5_pushes", n_push, 18);
    check("t5_bursts", n_hs, 4);
    check("t5_restart_addr", first_hs_addr, 32'h00);
    check_drained("t5");

    // 6a: empty frame
    hh = 0; vv = 5;
    clear_stats();
    pulse_sync();
    count_req_cycles(10, cnt);
    check("t6_hh0_no_req", cnt, 0);

    // 6b: reset while a request is pending
    hh = 8; vv = 1; ready_delay = 6;
    clear_stats(); plan_frame(BASE0, 8, 1);
    pulse_sync();
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge wr_clk);
      if (bus.rd_req_valid) found = 1;
    end
    check("t6_req_seen", found, 1);
    rst = 1;
    #1;
    check("t6_rst_req_valid", bus.rd_req_valid, 0);
    check("t6_rst_req_addr",  bus.rd_req_addr,  0);
    check("t6_rst_wr_en",     bus.fifo_wr_en,   0);
    check("t6_rst_done",      frame_done,       0);
    check("t6_rst_overflow",  overflow,         0);
    check("t6_rst_late",      late_frame,       0);
    tick(2);
    exp_req.delete(); exp_beat.delete();
    ready_delay = 2;
    rst = 0;
    count_req_cycles(8, cnt);
    check("t6_wait_sync_after_rst", cnt, 0);

    // 8: rd_data_last of the final burst coincides with frame_sync
    hh = 4; vv = 1;
    clear_stats(); plan_frame(BASE0, 4, 1);
    pulse_sync();
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick(1);
      if (bus.rd_data_valid && bus.rd_data_last) found = 1;
    end
    check("t8_last_seen", found, 1);
    plan_frame(BASE0, 4, 1);
    pulse_sync();
    wait_done("t8", 400);
    check("t8_late_stays_0", late_frame, 0);
    check("t8_pushes", n_push, 8);
    check("t8_bursts", n_hs, 2);
    check_drained("t8");

`ifdef LCD_FEEDER_PINGPONG_EN
    // 7: second frame buffer selected at sync
    buf_sel = 1; hh = 4; vv = 1;
    clear_stats(); plan_frame(BASE1, 4, 1);
    pulse_sync();
    buf_sel = 0;
    wait_done("t7", 400);
    check("t7_first_addr", first_hs_addr, 32'h0080_0000);
    check_drained("t7");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
